// File: rtl/hpf_complement.sv
// hpf_complement: first-order highpass, H(z) = (15z-15)/(16z-14), the complement of the lowpass.
// Latency: out/sat/out_valid update on the 4th clock edge after the capture edge; one sample per 5 clocks.
// Backpressure: in_ready is high only in IDLE; in_valid is ignored (never queued) while busy.
module hpf_complement #(
    parameter int W_IN  = 13,
    parameter int W_ACC = 21
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic signed [W_IN-1:0] in,
    output logic                   in_ready,
    output logic signed [W_IN-1:0] out,
    output logic                   out_valid,
    output logic                   sat
);

    localparam int W_D = W_IN + 1;   // difference of two W_IN samples never overflows
    localparam int W_P = W_IN + 5;   // 15*d needs 4 more bits than d

    // Output clip limits, held at accumulator width so comparisons stay signed and lossless
    localparam logic signed [W_ACC-1:0] Y_MAX = W_ACC'((1 << (W_IN - 1)) - 1);
    localparam logic signed [W_ACC-1:0] Y_MIN = ~Y_MAX;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        DIFF = 3'd1,
        MUL  = 3'd2,
        ACC  = 3'd3,
        OUT  = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic signed [W_IN-1:0]  x_reg;
    logic signed [W_IN-1:0]  x_1;
    logic signed [W_D-1:0]   d;
    logic signed [W_P-1:0]   p;
    logic signed [W_ACC-1:0] acc;

    logic signed [W_D-1:0]   d_next;
    logic signed [W_P-1:0]   d_ext;
    logic signed [W_P-1:0]   p_next;
    logic signed [W_ACC-1:0] p_ext;
    logic signed [W_ACC-1:0] acc_next;
    logic signed [W_ACC-1:0] acc_sh;
    logic signed [W_IN-1:0]  y_clip;
    logic                    y_sat;

    // Datapath arithmetic: each stage only consumes the register loaded by the previous state
    assign d_next   = {x_reg[W_IN-1], x_reg} - {x_1[W_IN-1], x_1};
    assign d_ext    = {{(W_P - W_D){d[W_D-1]}}, d};
    assign p_next   = (d_ext <<< 4) - d_ext;
    assign p_ext    = {{(W_ACC - W_P){p[W_P-1]}}, p};
    assign acc_next = acc - (acc >>> 3) + p_ext;
    assign acc_sh   = acc >>> 4;

    // Clip acc/16 to the output range; acc itself is never clipped
    always_comb begin
        y_clip = acc_sh[W_IN-1:0];
        y_sat  = 1'b0;
        if (acc_sh > Y_MAX) begin
            y_clip = Y_MAX[W_IN-1:0];
            y_sat  = 1'b1;
        end else if (acc_sh < Y_MIN) begin
            y_clip = Y_MIN[W_IN-1:0];
            y_sat  = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: one step per clock, leaving IDLE only on an accepted sample
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = in_valid ? DIFF : IDLE;
            DIFF:    state_nxt = MUL;
            MUL:     state_nxt = ACC;
            ACC:     state_nxt = OUT;
            OUT:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: ready only while waiting for a sample
    always_comb begin
        in_ready = (state == IDLE);
    end

    // Datapath registers; out/sat hold until the next OUT, out_valid is a single-cycle pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_reg     <= '0;
            x_1       <= '0;
            d         <= '0;
            p         <= '0;
            acc       <= '0;
            out       <= '0;
            sat       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_reg <= in;
                    end
                end
                DIFF: begin
                    d   <= d_next;
                    x_1 <= x_reg;
                end
                MUL: begin
                    p <= p_next;
                end
                ACC: begin
                    acc <= acc_next;
                end
                OUT: begin
                    out       <= y_clip;
                    sat       <= y_sat;
                    out_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
